dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-back, write-allocate data cache that sits directly downstream of the store buffer and beside the processor load path. It accepts drained stores (`sb_write_cache`/`sb_address`/`sb_data`) and processor loads, and answers with `dhit`/`rdata`. Misses are serviced over a line-wide request/ready handshake to main memory, with dirty-victim writeback first. A one-entry pending-write register absorbs store-buffer drains that arrive while the cache is busy.

## Interface
- `LINES`, 4: number of cache lines, a power of two; `IDX_W = log2(LINES)`.
- `WORDS`, 4: 32-bit words per line, fixed at 4, so lines are 128-bit.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. One clock, `clk`.
- `load` in 1: processor load request; held high until `dhit`.
- `load_addr` in 32: load byte address, word-aligned.
- `sb_write_cache` in 1: one-cycle store-drain pulse from the store buffer.
- `sb_address` in 32: store byte address, word-aligned.
- `sb_data` in 32: store data.
- `dhit` out 1: one-cycle pulse when the current request completes.
- `rdata` out 32: load data, valid while `dhit` is high for a load.
- `busy` out 1: high when the FSM is not IDLE or the pending-write register is occupied.
- `wr_overflow` out 1: sticky flag set when a store drain is lost; cleared only by reset.
- `mem_req` out 1: memory request, held until `mem_ready`.
- `mem_we` out 1: 1 = line writeback, 0 = line refill.
- `mem_addr` out 32: line address, with bits [3:0] = 0.
- `mem_wdata` out 128: victim line; word 0 in [31:0].
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_rdata` in 128: refill line, valid while `mem_ready` is high.

## Operation
- Address fields:
  - offset = [3:2]
  - index = [IDX_W+3:4]
  - tag = [31:IDX_W+4]
  - bits [1:0] are ignored.
- Per-line state: `valid`, `dirty`, tag, 128-bit data.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, DONE.
- IDLE:
  - Request source priority: pending write, then `load`, then a live `sb_write_cache`.
  - The chosen request (kind, address, data) is latched into the request register, and the FSM goes to LOOKUP.
- LOOKUP, hit (valid and tag equal):
  - Load: `rdata` = selected word.
  - Store: word merged into the line; `dirty` set.
  - `dhit` pulses; the FSM goes to IDLE.
- LOOKUP, miss: go to WRITEBACK if the victim is valid and dirty, otherwise go to REFILL.
- WRITEBACK:
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr` = {victim tag, index, 4'b0}, `mem_wdata` = victim line.
  - On `mem_ready`, go to REFILL.
- REFILL:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` = {request tag, index, 4'b0}.
  - On `mem_ready`, install `mem_rdata`, set `valid`=1, clear `dirty`, then go to DONE.
- DONE: complete the request as a hit (load word out, or store merge plus dirty), pulse `dhit`, return to IDLE.
- Store drains arriving while the FSM is not IDLE, or while losing arbitration in IDLE:
  - If the pending-write register is empty, the drain is captured there.
  - If it is full, the drain is dropped and `wr_overflow` is set.
- `load` must not deassert before `dhit`; a mid-miss address change is ignored because the request is latched.

## Timing
- Reset values:
  - `dhit`, `rdata`, `busy`, `wr_overflow`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`: all 0.
  - All `valid` and `dirty` bits cleared; FSM in IDLE; pending register empty.
- Hit latency: request sampled at edge N, `dhit` high for the cycle after edge N+1.
- Clean miss: `mem_req` rises after edge N+1. With `mem_ready` sampled at edge M, `dhit` is high after edge M+1.
- Dirty miss: WRITEBACK completion, then REFILL begins the next cycle.
- `mem_*` outputs are registered and stable while `mem_req`=1. `mem_ready` is ignored when `mem_req`=0.
- Reset asserted mid-miss: immediate return to the reset state. Any in-flight memory transaction is abandoned and memory must discard it.
- Store drain and load in the same IDLE cycle: the load wins and the drain goes to the pending register. The pending write is served right after the load completes.
- Back-to-back requests: IDLE accepts the next request the cycle after `dhit`.

## Structure
- Package `dcache_pkg`:
  - state enum `dcache_state_t`
  - `LINE_W`=128
  - offset/index/tag width constants
  - request-kind enum (LOAD, STORE)
- Sub-module `dcache_array`:
  - LINES × {valid, dirty, tag, data} storage
  - combinational read port, synchronous write port with word-enable
  - line-install port and asynchronous clear
- FSM, arbitration and the pending-write register live in `dcache`.

## Test plan
- Cold load at 0x0000_0040 → REFILL with `mem_addr`=0x40. `mem_rdata`={0x44,0x33,0x22,0x11} (word 3 to word 0) → `dhit` with `rdata`=0x11. A second load at 0x44 hits after 1 cycle with `rdata`=0x22.
- Store 0xDEAD_BEEF to 0x48 after that refill → hit, `dirty` set. A load at 0x48 returns 0xDEADBEEF.
- Load at 0x0000_0440 (same index as 0x40, different tag, LINES=4) with the line dirty → WRITEBACK with `mem_addr`=0x40 and word 2 of `mem_wdata` = 0xDEADBEEF, then REFILL with `mem_addr`=0x440.
- `load` at 0x80 and `sb_write_cache` (0x90, 0x5) in the same cycle → the load completes first. The store is served from the pending register next, and `busy` stays high throughout.
- Three store drains during a miss with `mem_ready` delayed 10 cycles → the first is captured pending, the second and third are dropped, and `wr_overflow`=1.
- `rst_n` pulled low during REFILL → outputs are 0 asynchronously. After release, a load at 0x40 misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int LINES  = 4;
  localparam int WORDS  = 4;
  localparam int WORD_W = 32;
  localparam int LINE_W = WORDS * WORD_W;
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_REFILL    = 3'd3,
    ST_DONE      = 3'd4
  } dcache_state_t;

  typedef enum logic {
    REQ_LOAD  = 1'b0,
    REQ_STORE = 1'b1
  } req_kind_t;

  // Rebuild a line-aligned byte address from its tag and index fields.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx);
    return {tag, idx, 4'b0000};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Line-wide memory bus between the cache (master) and main memory (slave).
//
// Handshake: the master raises mem_req together with mem_we/mem_addr/
// mem_wdata and holds all four stable until it samples mem_ready high on a
// rising edge; that edge completes the transfer. mem_rdata is only
// meaningful in that completing cycle of a refill (mem_we = 0). The slave
// must not raise mem_ready while mem_req is low, and the master ignores it
// if it does.
interface dcache_if;
  import dcache_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/dcache_array.sv
// Tag/state/data storage for the cache: combinational read of one line,
// word-enabled store write (marks the line dirty) and whole-line install
// (marks the line valid and clean). Everything clears on reset.
module dcache_array
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORDS-1:0]  wr_be,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              inst_en,
  input  logic [IDX_W-1:0]  inst_idx,
  input  logic [TAG_W-1:0]  inst_tag,
  input  logic [LINE_W-1:0] inst_data
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINE_W-1:0] data_d [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Next array contents: install first, then a store merge, so a store to a
  // freshly installed line (same cycle) would still land and mark it dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inst_en) begin
      valid_d[inst_idx] = 1'b1;
      dirty_d[inst_idx] = 1'b0;
      tag_d[inst_idx]   = inst_tag;
      data_d[inst_idx]  = inst_data;
    end
    if (wr_en) begin
      for (int w = 0; w < WORDS; w++) begin
        if (wr_be[w]) begin
          data_d[wr_idx][w*WORD_W +: WORD_W] = wr_data[w*WORD_W +: WORD_W];
        end
      end
      dirty_d[wr_idx] = 1'b1;
    end
  end

  // Storage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache. Arbitrates between a
// one-entry pending store, processor loads and live store-buffer drains,
// services misses over the line-wide memory bus (dirty victim first), and
// reports completion with a one-cycle dhit pulse.
module dcache
  import dcache_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [31:0]   load_addr,
  input  logic          sb_write_cache,
  input  logic [31:0]   sb_address,
  input  logic [31:0]   sb_data,
  output logic          dhit,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          wr_overflow,
  dcache_if.master      mem,
  output dcache_state_t state_o
);

  dcache_state_t     state_q, state_d;
  req_kind_t         req_kind_q, req_kind_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [31:0]       req_data_q, req_data_d;
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       pend_addr_q, pend_addr_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic              wr_overflow_q, wr_overflow_d;
  logic              dhit_q, dhit_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              arr_valid, arr_dirty;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_data;
  logic [WORDS-1:0][WORD_W-1:0] line_words;
  logic              arr_wr_en, arr_inst_en;
  logic [WORDS-1:0]  arr_wr_be;
  logic              hit, complete, take_pend, take_sb;
  logic              unused_addr_bits;

  assign req_off  = req_addr_q[3:2];
  assign req_idx  = req_addr_q[IDX_W+3:4];
  assign req_tag  = req_addr_q[31:IDX_W+4];
  assign hit      = arr_valid && (arr_tag == req_tag);
  assign line_words = arr_data;
  // Addresses are word-aligned; the byte-offset bits are carried but unused.
  assign unused_addr_bits = ^req_addr_q[1:0];

  dcache_array u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (req_idx),
    .rd_valid  (arr_valid),
    .rd_dirty  (arr_dirty),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data),
    .wr_en     (arr_wr_en),
    .wr_idx    (req_idx),
    .wr_be     (arr_wr_be),
    .wr_data   ({WORDS{req_data_q}}),
    .inst_en   (arr_inst_en),
    .inst_idx  (req_idx),
    .inst_tag  (req_tag),
    .inst_data (mem.mem_rdata)
  );

  // Next-state, request arbitration, memory bus and pending-write control.
  always_comb begin
    state_d       = state_q;
    req_kind_d    = req_kind_q;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    pend_valid_d  = pend_valid_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    wr_overflow_d = wr_overflow_q;
    dhit_d        = 1'b0;
    rdata_d       = rdata_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    arr_wr_en     = 1'b0;
    arr_inst_en   = 1'b0;
    arr_wr_be     = '0;
    arr_wr_be[req_off] = 1'b1;
    complete      = 1'b0;
    take_pend     = 1'b0;
    take_sb       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // During the dhit cycle the processor may still be holding the load
        // it just got answered, so a load is not taken in that cycle.
        if (pend_valid_q) begin
          take_pend  = 1'b1;
          req_kind_d = REQ_STORE;
          req_addr_d = pend_addr_q;
          req_data_d = pend_data_q;
          state_d    = ST_LOOKUP;
        end else if (load && !dhit_q) begin
          req_kind_d = REQ_LOAD;
          req_addr_d = load_addr;
          req_data_d = '0;
          state_d    = ST_LOOKUP;
        end else if (sb_write_cache) begin
          take_sb    = 1'b1;
          req_kind_d = REQ_STORE;
          req_addr_d = sb_address;
          req_data_d = sb_data;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          complete = 1'b1;
        end else if (arr_valid && arr_dirty) begin
          state_d     = ST_WRITEBACK;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = line_addr(arr_tag, req_idx);
          mem_wdata_d = arr_data;
        end else begin
          state_d    = ST_REFILL;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr(req_tag, req_idx);
        end
      end
      ST_WRITEBACK: begin
        // Keep mem_req high straight into the refill of the same index.
        if (mem_req_q && mem.mem_ready) begin
          state_d    = ST_REFILL;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr(req_tag, req_idx);
        end
      end
      ST_REFILL: begin
        if (mem_req_q && mem.mem_ready) begin
          arr_inst_en = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        complete = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Finish the latched request against the (now resident) line.
    if (complete) begin
      dhit_d  = 1'b1;
      state_d = ST_IDLE;
      if (req_kind_q == REQ_LOAD) begin
        rdata_d = line_words[req_off];
      end else begin
        arr_wr_en = 1'b1;
      end
    end

    // A drain that is not taken directly parks in the pending register if
    // it is free (or being emptied this cycle), otherwise it is lost.
    if (take_pend) begin
      pend_valid_d = 1'b0;
    end
    if (sb_write_cache && !take_sb) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = sb_address;
        pend_data_d  = sb_data;
      end else begin
        wr_overflow_d = 1'b1;
      end
    end
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_kind_q    <= REQ_LOAD;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      wr_overflow_q <= 1'b0;
      dhit_q        <= 1'b0;
      rdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      req_kind_q    <= req_kind_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      wr_overflow_q <= wr_overflow_d;
      dhit_q        <= dhit_d;
      rdata_q       <= rdata_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign dhit          = dhit_q;
  assign rdata         = rdata_q;
  assign busy          = (state_q != ST_IDLE) || pend_valid_q;
  assign wr_overflow   = wr_overflow_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a table of single-request vectors followed by
// hand-written sequences for arbitration, pending-write overflow and reset
// during a refill. Memory requests are checked against an expected queue.
module tb_dcache;
  import dcache_pkg::*;

  typedef struct {
    logic        is_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    int          exp_lat;
    logic        has_wb;
    logic [31:0] wb_addr;
    logic [127:0] wb_line;
    logic        has_rf;
    logic [31:0] rf_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [31:0]   load_addr = '0;
  logic          sb_write_cache = 1'b0;
  logic [31:0]   sb_address = '0;
  logic [31:0]   sb_data = '0;
  logic          dhit, busy, wr_overflow;
  logic [31:0]   rdata;
  dcache_state_t state_o;

  int n_vec = 0;
  int n_bad = 0;
  int mem_delay = 0;
  logic [160:0] exp_q[$];
  logic [127:0] backing [logic [27:0]];

  dcache_if mif ();

  dcache dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .load_addr      (load_addr),
    .sb_write_cache (sb_write_cache),
    .sb_address     (sb_address),
    .sb_data        (sb_data),
    .dhit           (dhit),
    .rdata          (rdata),
    .busy           (busy),
    .wr_overflow    (wr_overflow),
    .mem            (mif),
    .state_o        (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: answers each request after mem_delay cycles and checks it
  // against the head of the expected-request queue.
  initial begin
    int wait_cnt;
    logic [160:0] e;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      mif.mem_ready = 1'b0;
      if (!rst_n || !mif.mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt < mem_delay) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL mem_unexpected: got we=%0b addr=%08h, expected no request",
                   mif.mem_we, mif.mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("mem_we", 128'(mif.mem_we), 128'(e[160]));
          check("mem_addr", 128'(mif.mem_addr), 128'(e[159:128]));
          if (e[160]) check("mem_wdata", mif.mem_wdata, e[127:0]);
        end
        if (mif.mem_we) begin
          backing[mif.mem_addr[31:4]] = mif.mem_wdata;
        end else begin
          mif.mem_rdata = backing.exists(mif.mem_addr[31:4]) ? backing[mif.mem_addr[31:4]] : '0;
        end
        mif.mem_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic is_ld, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    if (is_ld) begin
      load = 1'b1;
      load_addr = a;
    end else begin
      sb_write_cache = 1'b1;
      sb_address = a;
      sb_data = d;
    end
    @(posedge clk);
    #1 sb_write_cache = 1'b0;
  endtask

  // Cycles are counted at falling edges after the sampling edge.
  task automatic wait_dhit(input string name, input int bound, output int lat);
    logic found;
    found = 1'b0;
    lat = 0;
    while (!found && lat < bound) begin
      @(negedge clk);
      lat++;
      if (dhit) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: no dhit within %0d cycles", name, bound);
      exp_q.delete();
    end
    load = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    mem_delay = v.delay;
    if (v.has_wb) exp_q.push_back({1'b1, v.wb_addr, v.wb_line});
    if (v.has_rf) exp_q.push_back({1'b0, v.rf_addr, 128'h0});
    issue(v.is_ld, v.addr, v.wdata);
    wait_dhit(name, 80, lat);
    check({name, " latency"}, 128'(lat), 128'(v.exp_lat));
    if (v.is_ld) check({name, " rdata"}, 128'(rdata), 128'(v.exp_rdata));
    check({name, " mem reqs outstanding"}, 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [127:0] ln(input logic [31:0] w3, input logic [31:0] w2,
                                      input logic [31:0] w1, input logic [31:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  // ---------------- test ----------------
  vec_t vt[12];

  initial begin
    int cyc, nd, gaps;

    backing[28'h004] = ln(32'h44, 32'h33, 32'h22, 32'h11);
    backing[28'h044] = ln(32'hA3, 32'hA2, 32'hA1, 32'hA0);
    backing[28'h000] = ln(32'hC3, 32'hC2, 32'hC1, 32'hC0);
    backing[28'h001] = ln(32'hD3, 32'hD2, 32'hD1, 32'hD0);
    backing[28'h040] = ln(32'hE3, 32'hE2, 32'hE1, 32'hE0);
    backing[28'h008] = ln(32'hF3, 32'hF2, 32'hF1, 32'hF0);
    backing[28'h009] = ln(32'h93, 32'h92, 32'h91, 32'h90);
    backing[28'h00C] = ln(32'hB3, 32'hB2, 32'hB1, 32'hB0);
    backing[28'h002] = ln(32'h23, 32'h22, 32'h21, 32'h20);

    //           ld    addr          wdata         dly lat wb    wb_addr  wb_line                                         rf    rf_addr  rdata
    vt[0]  = '{1'b1, 32'h40,  32'h0,         0, 4, 1'b0, 32'h0,  128'h0,                                         1'b1, 32'h40,  32'h11};
    vt[1]  = '{1'b1, 32'h44,  32'h0,         0, 2, 1'b0, 32'h0,  128'h0,                                         1'b0, 32'h0,   32'h22};
    vt[2]  = '{1'b0, 32'h48,  32'hDEADBEEF,  0, 2, 1'b0, 32'h0,  128'h0,                                         1'b0, 32'h0,   32'h0};
    vt[3]  = '{1'b1, 32'h48,  32'h0,         0, 2, 1'b0, 32'h0,  128'h0,                                         1'b0, 32'h0,   32'hDEADBEEF};
    vt[4]  = '{1'b1, 32'h440, 32'h0,         0, 5, 1'b1, 32'h40, ln(32'h44, 32'hDEADBEEF, 32'h22, 32'h11),        1'b1, 32'h440, 32'hA0};
    vt[5]  = '{1'b1, 32'h48,  32'h0,         0, 4, 1'b0, 32'h0,  128'h0,                                         1'b1, 32'h40,  32'hDEADBEEF};
    vt[6]  = '{1'b0, 32'h0C,  32'h12345678,  0, 4, 1'b0, 32'h0,  128'h0,                                         1'b1, 32'h00,  32'h0};
    vt[7]  = '{1'b1, 32'h0C,  32'h0,         0, 2, 1'b0, 32'h0,  128'h0,                                         1'b0, 32'h0,   32'h12345678};
    vt[8]  = '{1'b1, 32'h14,  32'h0,         3, 7, 1'b0, 32'h0,  128'h0,                                         1'b1, 32'h10,  32'hD1};
    vt[9]  = '{1'b0, 32'h1C,  32'h0BADF00D,  0, 2, 1'b0, 32'h0,  128'h0,                                         1'b0, 32'h0,   32'h0};
    vt[10] = '{1'b1, 32'h00,  32'h0,         0, 2, 1'b0, 32'h0,  128'h0,                                         1'b0, 32'h0,   32'hC0};
    vt[11] = '{1'b1, 32'h404, 32'h0,         1, 7, 1'b1, 32'h00, ln(32'h12345678, 32'hC2, 32'hC1, 32'hC0),        1'b1, 32'h400, 32'hE1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset dhit", 128'(dhit), 128'(0));
    check("reset rdata", 128'(rdata), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    check("reset wr_overflow", 128'(wr_overflow), 128'(0));
    check("reset mem_req", 128'(mif.mem_req), 128'(0));
    check("reset mem_we", 128'(mif.mem_we), 128'(0));
    check("reset mem_addr", 128'(mif.mem_addr), 128'(0));
    check("reset mem_wdata", mif.mem_wdata, 128'(0));
    check("reset state", 128'(state_o), 128'(ST_IDLE));
    #2 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Load and drain in the same cycle: load first, drain from pending next.
    mem_delay = 0;
    exp_q.push_back({1'b0, 32'h80, 128'h0});
    exp_q.push_back({1'b1, 32'h10, ln(32'h0BADF00D, 32'hD2, 32'hD1, 32'hD0)});
    exp_q.push_back({1'b0, 32'h90, 128'h0});
    @(negedge clk);
    load = 1'b1; load_addr = 32'h80;
    sb_write_cache = 1'b1; sb_address = 32'h90; sb_data = 32'h5;
    @(posedge clk);
    #1 sb_write_cache = 1'b0;
    cyc = 0; nd = 0; gaps = 0;
    while (nd < 2 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (dhit) begin
        nd++;
        if (nd == 1) begin
          check("b load rdata", 128'(rdata), 128'h0F0);
          check("b load cycle", 128'(cyc), 128'(4));
          check("b busy at load dhit", 128'(busy), 128'(1));
          load = 1'b0;
        end else begin
          check("b store cycle", 128'(cyc), 128'(9));
          check("b busy at store dhit", 128'(busy), 128'(0));
        end
      end else if (!busy) begin
        gaps++;
      end
    end
    check("b dhit count", 128'(nd), 128'(2));
    check("b busy gaps", 128'(gaps), 128'(0));
    check("b mem reqs outstanding", 128'(exp_q.size()), 128'(0));
    load = 1'b0;
    run_vec('{1'b1, 32'h90, 32'h0, 0, 2, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h5}, "b load 0x90");

    // Three drains during a slow miss: one parked, two lost.
    check("c overflow before", 128'(wr_overflow), 128'(0));
    mem_delay = 10;
    exp_q.push_back({1'b0, 32'hC0, 128'h0});
    exp_q.push_back({1'b0, 32'h20, 128'h0});
    @(negedge clk);
    load = 1'b1; load_addr = 32'hC0;
    @(posedge clk);
    #1;
    cyc = 0; nd = 0;
    while (nd < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (dhit) begin
        nd++;
        if (nd == 1) begin
          check("c load rdata", 128'(rdata), 128'h0B0);
          check("c load cycle", 128'(cyc), 128'(14));
          load = 1'b0;
          mem_delay = 0;
        end else begin
          check("c pending store cycle", 128'(cyc), 128'(18));
        end
      end
      sb_write_cache = (cyc >= 2 && cyc <= 4);
      sb_address = 32'h20 + 32'(4 * (cyc - 2));
      sb_data = 32'(cyc - 1);
    end
    sb_write_cache = 1'b0;
    load = 1'b0;
    check("c dhit count", 128'(nd), 128'(2));
    check("c overflow after", 128'(wr_overflow), 128'(1));
    run_vec('{1'b1, 32'h20, 32'h0, 0, 2, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h1},  "c load 0x20");
    run_vec('{1'b1, 32'h24, 32'h0, 0, 2, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h21}, "c load 0x24");
    run_vec('{1'b1, 32'h28, 32'h0, 0, 2, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h22}, "c load 0x28");

    // Reset in the middle of a refill.
    mem_delay = 50;
    @(negedge clk);
    load = 1'b1; load_addr = 32'h40;
    @(posedge clk);
    #1;
    repeat (3) @(negedge clk);
    check("d mem_req in refill", 128'(mif.mem_req), 128'(1));
    check("d state in refill", 128'(state_o), 128'(ST_REFILL));
    check("d mem_addr in refill", 128'(mif.mem_addr), 128'h40);
    #2 rst_n = 1'b0;
    #1;
    check("d async mem_req", 128'(mif.mem_req), 128'(0));
    check("d async mem_addr", 128'(mif.mem_addr), 128'(0));
    check("d async busy", 128'(busy), 128'(0));
    check("d async overflow", 128'(wr_overflow), 128'(0));
    check("d async state", 128'(state_o), 128'(ST_IDLE));
    load = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    mem_delay = 0;
    run_vec('{1'b1, 32'h40, 32'h0, 0, 4, 1'b0, 32'h0, 128'h0, 1'b1, 32'h40, 32'h11}, "d reload 0x40");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
